// File: rtl/op_amp_pkg.sv
// rtl/op_amp_pkg.sv - shared types, default constants and clamp helper for the op_amp model
package op_amp_pkg;

   // Voltages on pins, in millivolts
   typedef logic signed [15:0] mv_t;

   // Differential input, wide enough for any pin3 - pin2
   typedef logic signed [16:0] diff_t;

   // Trimmed differential and rail levels; also used for slew step arithmetic
   typedef logic signed [17:0] trim_t;

   // Exact product of trimmed differential and open-loop gain
   typedef logic signed [33:0] wide_t;

   // Default electrical characteristics of the part
   localparam int unsigned DEF_GAIN        = 100;
   localparam int unsigned DEF_HEADROOM    = 1500;
   localparam int unsigned DEF_SLEW_MAX    = 16000;
   localparam int unsigned DEF_OFFSET_TRIM = 2;

   // Input-stage snapshot taken every clock
   typedef struct packed {
      mv_t  inv;
      mv_t  noninv;
      mv_t  vee;
      mv_t  vcc;
      logic null_a;
      logic null_b;
   } in_regs_t;

   // Clamp the ideal output into [lo, hi]; the caller guarantees lo <= hi,
   // so the clamped value always lies inside the 16-bit pin range
   function automatic mv_t clamp_to_rails(wide_t ideal, trim_t lo, trim_t hi);
      wide_t lo_w;
      wide_t hi_w;
      wide_t res;
      lo_w = wide_t'(lo);
      hi_w = wide_t'(hi);
      if (ideal > hi_w) begin
         res = hi_w;
      end else if (ideal < lo_w) begin
         res = lo_w;
      end else begin
         res = ideal;
      end
      return mv_t'(res);
   endfunction

endpackage

// File: rtl/op_amp_slew_limiter.sv
// rtl/op_amp_slew_limiter.sv - output register that follows its target at a bounded rate
module op_amp_slew_limiter
   import op_amp_pkg::*;
#(
   parameter int unsigned SLEW_MAX = DEF_SLEW_MAX
) (
   input  logic clk,
   input  logic rst,
   input  mv_t  target_i,
   output mv_t  out_o
);

   mv_t   out_q;
   mv_t   out_d;
   trim_t step;
   trim_t pos_lim;
   trim_t neg_lim;

   // Move toward the target, jumping straight onto it when it is within one slew step
   always_comb begin
      pos_lim = trim_t'(SLEW_MAX);
      neg_lim = -pos_lim;
      step    = trim_t'(target_i) - trim_t'(out_q);
      out_d   = target_i;
      if (step > pos_lim) begin
         out_d = mv_t'(trim_t'(out_q) + pos_lim);
      end else if (step < neg_lim) begin
         out_d = mv_t'(trim_t'(out_q) + neg_lim);
      end
   end

   // Output register; reset forces 0 immediately, bypassing the slew limit
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out_o = out_q;

endmodule

// File: rtl/op_amp.sv
// rtl/op_amp.sv - cycle-based 8-pin op-amp: gain, rail clamp and slew-limited output
module op_amp
   import op_amp_pkg::*;
#(
   parameter int unsigned GAIN        = DEF_GAIN,
   parameter int unsigned HEADROOM    = DEF_HEADROOM,
   parameter int unsigned SLEW_MAX    = DEF_SLEW_MAX,
   parameter int unsigned OFFSET_TRIM = DEF_OFFSET_TRIM
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pin1_offset_null,
   input  logic signed [15:0] pin2_inv_input,
   input  logic signed [15:0] pin3_noninv_input,
   input  logic signed [15:0] pin4_vee,
   input  logic               pin5_offset_null,
   output logic signed [15:0] pin6_output,
   input  logic signed [15:0] pin7_vcc,
   input  logic               pin8_nc
);

   in_regs_t in_q;
   in_regs_t in_d;
   mv_t      target_q;
   mv_t      target_d;

   diff_t    diff;
   trim_t    trimmed;
   wide_t    ideal;
   trim_t    out_max;
   trim_t    out_min;
   mv_t      slew_out;

   // The no-connect pin is deliberately left without any function
   logic     unused_pin8;
   assign unused_pin8 = pin8_nc;

   // Gather the pins sampled by the input stage
   always_comb begin
      in_d        = '0;
      in_d.inv    = pin2_inv_input;
      in_d.noninv = pin3_noninv_input;
      in_d.vee    = pin4_vee;
      in_d.vcc    = pin7_vcc;
      in_d.null_a = pin1_offset_null;
      in_d.null_b = pin5_offset_null;
   end

   // Input stage: signal, supply and offset-null pins all move together
   always_ff @(posedge clk) begin
      if (rst) begin
         in_q <= '0;
      end else begin
         in_q <= in_d;
      end
   end

   // Differential, offset trim, gain and rail clamp on the captured inputs
   always_comb begin
      diff    = diff_t'(in_q.noninv) - diff_t'(in_q.inv);
      trimmed = trim_t'(diff);
      // Only one offset-null pin pulled selects a trim; both or neither cancel
      if (in_q.null_a && !in_q.null_b) begin
         trimmed = trim_t'(diff) + trim_t'(OFFSET_TRIM);
      end else if (in_q.null_b && !in_q.null_a) begin
         trimmed = trim_t'(diff) - trim_t'(OFFSET_TRIM);
      end
      ideal   = wide_t'(trimmed) * wide_t'(GAIN);
      out_max = trim_t'(in_q.vcc) - trim_t'(HEADROOM);
      out_min = trim_t'(in_q.vee) + trim_t'(HEADROOM);
      // A collapsed or inverted supply leaves no valid output window
      if (out_max < out_min) begin
         target_d = '0;
      end else begin
         target_d = clamp_to_rails(ideal, out_min, out_max);
      end
   end

   // Target register feeding the slew stage
   always_ff @(posedge clk) begin
      if (rst) begin
         target_q <= '0;
      end else begin
         target_q <= target_d;
      end
   end

   op_amp_slew_limiter #(
      .SLEW_MAX (SLEW_MAX)
   ) u_slew (
      .clk      (clk),
      .rst      (rst),
      .target_i (target_q),
      .out_o    (slew_out)
   );

   assign pin6_output = slew_out;

endmodule

// File: tb/tb_op_amp.sv
// tb/tb_op_amp.sv - self-checking bench for op_amp against a per-edge arithmetic model
module tb_op_amp;

   logic               clk;
   logic               rst;
   logic               pin1_offset_null;
   logic signed [15:0] pin2_inv_input;
   logic signed [15:0] pin3_noninv_input;
   logic signed [15:0] pin4_vee;
   logic               pin5_offset_null;
   logic signed [15:0] pin6_output;
   logic signed [15:0] pin7_vcc;
   logic               pin8_nc;

   int errors = 0;
   int checks = 0;

   // Per-edge history: reset flag and the target the inputs at that edge imply
   longint tgt_h [0:1023];
   bit     rst_h [0:1023];
   int     edge_n = 0;
   longint model_out = 0;

   op_amp dut (
      .clk               (clk),
      .rst               (rst),
      .pin1_offset_null  (pin1_offset_null),
      .pin2_inv_input    (pin2_inv_input),
      .pin3_noninv_input (pin3_noninv_input),
      .pin4_vee          (pin4_vee),
      .pin5_offset_null  (pin5_offset_null),
      .pin6_output       (pin6_output),
      .pin7_vcc          (pin7_vcc),
      .pin8_nc           (pin8_nc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint ideal_target(longint inv, longint noninv, longint vee, longint vcc,
                                           bit a, bit b);
      longint d;
      longint hi;
      longint lo;
      longint v;
      d = noninv - inv;
      if (a && !b) d = d + 2;
      if (b && !a) d = d - 2;
      v  = d * 100;
      hi = vcc - 1500;
      lo = vee + 1500;
      if (hi < lo) return 0;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint slew(longint prev, longint t);
      if (t - prev > 16000) return prev + 16000;
      if (t - prev < -16000) return prev - 16000;
      return t;
   endfunction

   task automatic tick(input string tag);
      longint eff;
      logic signed [15:0] exp16;
      @(posedge clk);
      rst_h[edge_n] = rst;
      tgt_h[edge_n] = ideal_target(longint'(pin2_inv_input), longint'(pin3_noninv_input),
                                   longint'(pin4_vee), longint'(pin7_vcc),
                                   pin1_offset_null, pin5_offset_null);
      if (edge_n >= 2 && !rst_h[edge_n-1] && !rst_h[edge_n-2]) eff = tgt_h[edge_n-2];
      else eff = 0;
      if (rst) model_out = 0;
      else model_out = slew(model_out, eff);
      edge_n++;
      #1;
      exp16 = 16'(model_out);
      checks++;
      assert (pin6_output === exp16)
         else begin
            errors++;
            $error("FAIL %s: pin6_output=%0d expected=%0d", tag, pin6_output, exp16);
         end
   endtask

   task automatic expect_val(input string tag, input int val);
      logic signed [15:0] exp16;
      exp16 = 16'(val);
      checks++;
      assert (pin6_output === exp16)
         else begin
            errors++;
            $error("FAIL %s: pin6_output=%0d expected=%0d", tag, pin6_output, exp16);
         end
   endtask

   task automatic set_in(input int inv, input int noninv);
      pin2_inv_input    = 16'(inv);
      pin3_noninv_input = 16'(noninv);
   endtask

   task automatic set_rails(input int vcc, input int vee);
      pin7_vcc = 16'(vcc);
      pin4_vee = 16'(vee);
   endtask

   initial begin
      rst = 1'b1;
      pin1_offset_null = 1'b0;
      pin5_offset_null = 1'b0;
      pin8_nc = 1'b0;
      set_in(0, 0);
      set_rails(15000, -15000);

      tick("reset0");
      tick("reset1");
      expect_val("reset_out", 0);
      rst = 1'b0;
      repeat (3) tick("post_reset");
      expect_val("post_reset_out", 0);

      set_in(100, 110);
      repeat (3) tick("pos_gain");
      expect_val("gain_plus_1000", 1000);

      set_in(110, 100);
      repeat (3) tick("neg_gain");
      expect_val("gain_minus_1000", -1000);

      set_in(0, 500);
      repeat (3) tick("sat_pos");
      expect_val("sat_plus_13500", 13500);
      tick("sat_pos_hold");
      expect_val("sat_plus_hold", 13500);

      set_in(500, 0);
      tick("swing1");
      tick("swing2");
      tick("swing3");
      expect_val("swing_mid_minus_2500", -2500);
      tick("swing4");
      expect_val("swing_final_minus_13500", -13500);

      set_in(200, 200);
      repeat (3) tick("equal_in");
      expect_val("equal_in_zero", 0);
      pin1_offset_null = 1'b1;
      repeat (3) tick("trim_pos");
      expect_val("trim_plus_200", 200);
      pin1_offset_null = 1'b0;
      pin5_offset_null = 1'b1;
      repeat (3) tick("trim_neg");
      expect_val("trim_minus_200", -200);
      pin1_offset_null = 1'b1;
      repeat (3) tick("trim_both");
      expect_val("trim_both_zero", 0);
      for (int i = 0; i < 4; i++) begin
         pin8_nc = ~pin8_nc;
         tick("pin8_toggle");
         expect_val("pin8_no_effect", 0);
      end
      pin1_offset_null = 1'b0;
      pin5_offset_null = 1'b0;

      set_rails(5000, -5000);
      set_in(0, 500);
      repeat (3) tick("low_rails");
      expect_val("low_rails_3500", 3500);
      set_rails(1000, 0);
      repeat (3) tick("collapsed");
      expect_val("collapsed_zero", 0);

      set_rails(15000, -15000);
      set_in(500, 0);
      repeat (4) tick("pre_slew");
      expect_val("pre_slew_minus_13500", -13500);
      set_in(0, 500);
      repeat (3) tick("mid_slew");
      expect_val("mid_slew_2500", 2500);
      rst = 1'b1;
      tick("rst_mid_slew");
      expect_val("rst_mid_slew_zero", 0);
      rst = 1'b0;
      repeat (4) tick("after_rst");
      expect_val("after_rst_13500", 13500);

      for (int i = 0; i < 300; i++) begin
         set_in(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
         if ($urandom_range(0, 3) == 0) begin
            set_in(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300);
         end
         if ($urandom_range(0, 7) == 0) begin
            set_rails(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
         end else begin
            set_rails(int'($urandom_range(2000, 15000)), -int'($urandom_range(2000, 15000)));
         end
         pin1_offset_null = 1'($urandom_range(0, 1));
         pin5_offset_null = 1'($urandom_range(0, 1));
         pin8_nc          = 1'($urandom_range(0, 1));
         rst              = ($urandom_range(0, 19) == 0);
         tick("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/op_amp.md
# op_amp

Cycle-based behavioural model of a classic 8-pin operational amplifier IC. All voltages are signed 16-bit integers in millivolts. It computes open-loop gain on the differential input, clamps the result to the supply rails minus headroom, and slew-limits the output. It is a leaf block, used standalone or inside mixed-signal system models.

## Interface
- GAIN, 100: open-loop gain applied to the differential input (unsigned, 1..65535)
- HEADROOM, 1500: mV between each supply rail and the output saturation level
- SLEW_MAX, 16000: maximum output change per clock, in mV (positive)
- OFFSET_TRIM, 2: mV added to or subtracted from the differential input by the offset-null pins
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pin1_offset_null  in  1  offset-null A; positive trim
- pin2_inv_input  in  16 signed  inverting input, mV
- pin3_noninv_input  in  16 signed  non-inverting input, mV
- pin4_vee  in  16 signed  negative supply, mV (e.g. -15000)
- pin5_offset_null  in  1  offset-null B; negative trim
- pin6_output  out  16 signed  amplifier output, mV
- pin7_vcc  in  16 signed  positive supply, mV (e.g. +15000)
- pin8_nc  in  1  no connect; ignored

## Operation
- Stage 1 (input register): capture pin2, pin3, pin4, pin7, pin1, pin5 each clock.
- Differential: diff = pin3 − pin2, 17-bit signed, no overflow.
- Trim: if pin1=1 and pin5=0, add OFFSET_TRIM. If pin5=1 and pin1=0, subtract OFFSET_TRIM. Otherwise no trim. Result is 18-bit signed.
- Gain: ideal = trimmed_diff × GAIN, 34-bit signed, exact.
- Rails: out_max = vcc − HEADROOM and out_min = vee + HEADROOM, both 18-bit signed.
  - If out_max < out_min (invalid or collapsed supply), target = 0.
  - Otherwise target = clamp(ideal, out_min, out_max).
- Stage 2: register target; it always fits in 16 bits after clamping.
- Slew stage: step = target − pin6_output.
  - If |step| ≤ SLEW_MAX, the output takes target.
  - Otherwise the output moves SLEW_MAX toward target.
  - Arithmetic is 18-bit signed, so no wrap.
- pin8 has no effect under any condition.

## Timing
- Reset: pin6_output and all pipeline registers are 0 on the first rising edge with rst=1. Reset asserted mid-slew forces the output to 0 on that edge, with no slewing.
- Latency: an input change reaches the slew-stage target after 2 edges. The output equals target on the 3rd edge if the step is ≤ SLEW_MAX.
- Full-swing step +13500 → −13500 (27000 mV) settles in 2 slew cycles, so the result is final 4 edges after the input change.
- Supply-pin changes follow the same 2-edge latency as signal inputs.
- Simultaneous input and rail changes: both are sampled on the same edge and used together.

## Structure
- Package op_amp_pkg holds:
  - the mV typedef (signed 16-bit)
  - the wide intermediate typedefs (17/18/34-bit)
  - the default constants for GAIN, HEADROOM, SLEW_MAX and OFFSET_TRIM
- One sub-module, op_amp_slew_limiter:
  - inputs: clk, rst, target, SLEW_MAX
  - output: the registered, slew-limited value

## Test plan
- Rails ±15000. Assert rst for 2 cycles, then pin2=pin3=0 → pin6=0 during and after reset.
- pin2=100, pin3=110 → pin6=+1000 after 3 edges. Swap the inputs → pin6=−1000.
- pin2=0, pin3=500 → pin6=+13500 (saturated), reached by the 4th edge; intermediate values move ≤16000 per cycle.
- pin2=500, pin3=0, starting from +13500 → pin6=−2500 after the 3rd edge, then −13500 on the 4th edge.
- pin2=pin3=200 → pin6=0. Then pin1=1 → +200. Then pin5=1 with pin1=0 → −200. Then both pins high → 0. pin8 toggling changes nothing.
- Rails +5000/−5000 with diff 500 → pin6=+3500. Rails vcc=1000, vee=0 (collapsed) → pin6=0. Assert rst mid-slew → pin6=0 on the next edge.
